// File: rtl/pgpmem_pingpong_sched_pkg.sv
// Shared geometry, bank-state and FSM encodings for the pgpmem ping-pong scheduler.
package pgpmem_pingpong_sched_pkg;
    localparam int PGPMEM_BANKS      = 2;
    localparam int PGPMEM_DEPTH      = 4096;
    localparam int WEIGHTMEM_CLK_DIV = 2;

    typedef logic [$clog2(PGPMEM_DEPTH/PGPMEM_BANKS)-1:0] PgpHalfAddr;

    typedef enum logic [1:0] {FREE, LOADING, FULL, READING} PgpBankState;
    typedef enum logic       {LD_IDLE, LD_LOAD}             pgp_ld_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_READ}    pgp_rd_state_e;

    // A bank holds a complete tile from the end of its load until its last read.
    function automatic logic bank_holds_tile(PgpBankState s);
        return (s == FULL) || (s == READING);
    endfunction
endpackage

// File: rtl/pgpmem_addrgen.sv
// Bank-local offset generator: steps through [0, limit) by step, repeated passes times.
module pgpmem_addrgen #(
    parameter int OFF_W = 11,
    parameter int LIM_W = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             advance,
    input  logic [LIM_W-1:0] step,
    input  logic [LIM_W-1:0] limit,
    input  logic [CNT_W-1:0] passes,
    output logic [OFF_W-1:0] offset,
    output logic             last
);
    logic [LIM_W-1:0] lim_q;
    logic [CNT_W-1:0] passes_q;
    logic [CNT_W-1:0] pass_cnt;
    logic             wrap;

    assign wrap = (LIM_W'(offset) + step) == lim_q;
    assign last = wrap && (pass_cnt == passes_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            offset   <= '0;
            pass_cnt <= '0;
            lim_q    <= '0;
            passes_q <= '0;
        end else if (start) begin
            offset   <= '0;
            pass_cnt <= '0;
            lim_q    <= limit;
            passes_q <= passes;
        end else if (advance) begin
            if (wrap) begin
                offset   <= '0;
                pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                offset <= offset + OFF_W'(step);
            end
        end
    end
endmodule

// File: rtl/pgpmem_pingpong_sched.sv
// Ping-pong scheduler for pgpmem: the loader fills one half while the MXU side
// streams the other half cfg_reuse times.
//   load state | meaning
//   LD_IDLE    | waiting for bank[wbank] FREE and a loader word
//   LD_LOAD    | passing accepted words through to pgpmem
//   read state | meaning
//   RD_IDLE    | no read request pending
//   RD_WAIT    | request latched, waiting for bank[rbank] FULL
//   RD_READ    | one rdreq per cycle until the last pass ends
module pgpmem_pingpong_sched
    import pgpmem_pingpong_sched_pkg::*;
#(
    parameter int DW      = 256,
    parameter int DEPTH   = PGPMEM_DEPTH,
    parameter int CLK_DIV = WEIGHTMEM_CLK_DIV,
    parameter int REUSE_W = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int HW = AW - 1,
    localparam int TW = HW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TW-1:0]      cfg_tile_words,
    input  logic [REUSE_W-1:0] cfg_reuse,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [DW-1:0]      ld_data,
    input  logic               rd_start,
    output logic               rd_busy,
    output logic               rd_done,
    output logic               mem_wrreq,
    output logic [AW-1:0]      mem_wraddress,
    output logic [DW-1:0]      mem_d,
    input  logic               mem_ready,
    output logic               mem_rdreq,
    output logic [AW-1:0]      mem_rdaddress,
    output logic [1:0]         bank_full,
    output logic               cfg_err
);
    localparam logic [TW-1:0] HALF_WORDS = TW'(DEPTH / 2);
    localparam logic [TW-1:0] RD_STEP    = TW'(CLK_DIV);
    localparam logic [TW-1:0] WR_STEP    = TW'(1);

    PgpBankState        bank_st    [PGPMEM_BANKS];
    logic [TW-1:0]      bank_words [PGPMEM_BANKS];
    logic               wbank, rbank;
    pgp_ld_state_e      ld_st, ld_nxt;
    pgp_rd_state_e      rd_st, rd_nxt;
    logic               tile_legal, ld_req, ld_go, ld_accept, wr_last;
    logic               rd_go, rd_last;
    logic [HW-1:0]      wr_off, rd_off;
    logic [REUSE_W-1:0] reuse_eff;

    assign tile_legal = (cfg_tile_words != '0) && ((cfg_tile_words % RD_STEP) == '0)
                        && (cfg_tile_words <= HALF_WORDS);
    assign ld_req     = (bank_st[wbank] == FREE) && ld_valid;
    assign ld_accept  = ld_ready && ld_valid;
    assign reuse_eff  = (cfg_reuse == '0) ? REUSE_W'(1) : cfg_reuse;
    assign bank_full  = {bank_holds_tile(bank_st[1]), bank_holds_tile(bank_st[0])};

    always_ff @(posedge clk) begin
        if (reset) ld_st <= LD_IDLE;
        else       ld_st <= ld_nxt;
    end

    always_comb begin
        ld_nxt = ld_st;
        case (ld_st)
            LD_IDLE: if (ld_req && tile_legal) ld_nxt = LD_LOAD;
            LD_LOAD: if (ld_accept && wr_last) ld_nxt = LD_IDLE;
            default: ld_nxt = LD_IDLE;
        endcase
    end

    always_comb begin
        ld_ready = 1'b0;
        ld_go    = 1'b0;
        cfg_err  = 1'b0;
        case (ld_st)
            LD_IDLE: begin
                ld_go   = ld_req && tile_legal;
                cfg_err = ld_req && !tile_legal;
            end
            LD_LOAD: ld_ready = mem_ready;
            default: ;
        endcase
    end

    // Write side is a pure passthrough of the accepted word, zeroed otherwise.
    assign mem_wrreq     = ld_accept;
    assign mem_wraddress = ld_accept ? {wbank, wr_off} : '0;
    assign mem_d         = ld_accept ? ld_data : '0;

    always_ff @(posedge clk) begin
        if (reset) rd_st <= RD_IDLE;
        else       rd_st <= rd_nxt;
    end

    always_comb begin
        rd_nxt = rd_st;
        case (rd_st)
            RD_IDLE: if (rd_start) rd_nxt = RD_WAIT;
            RD_WAIT: if (bank_st[rbank] == FULL) rd_nxt = RD_READ;
            RD_READ: if (rd_last) rd_nxt = RD_IDLE;
            default: rd_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_busy       = (rd_st != RD_IDLE);
        rd_go         = (rd_st == RD_WAIT) && (bank_st[rbank] == FULL);
        mem_rdreq     = (rd_st == RD_READ);
        rd_done       = (rd_st == RD_READ) && rd_last;
        mem_rdaddress = (rd_st == RD_READ) ? {rbank, rd_off} : '0;
    end

    // Load and read sides never touch the same bank in one cycle: each only
    // moves banks out of the states it owns.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < PGPMEM_BANKS; b++) begin
                bank_st[b]    <= FREE;
                bank_words[b] <= '0;
            end
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            if (ld_go) begin
                bank_st[wbank]    <= LOADING;
                bank_words[wbank] <= cfg_tile_words;
            end
            if (ld_accept && wr_last) begin
                bank_st[wbank] <= FULL;
                wbank          <= ~wbank;
            end
            if (rd_go) bank_st[rbank] <= READING;
            if (rd_done) begin
                bank_st[rbank] <= FREE;
                rbank          <= ~rbank;
            end
        end
    end

    pgpmem_addrgen #(.OFF_W(HW), .LIM_W(TW), .CNT_W(1)) u_wr_gen (
        .clk     (clk),
        .reset   (reset),
        .start   (ld_go),
        .advance (ld_accept),
        .step    (WR_STEP),
        .limit   (cfg_tile_words),
        .passes  (1'b1),
        .offset  (wr_off),
        .last    (wr_last)
    );

    pgpmem_addrgen #(.OFF_W(HW), .LIM_W(TW), .CNT_W(REUSE_W)) u_rd_gen (
        .clk     (clk),
        .reset   (reset),
        .start   (rd_go),
        .advance (mem_rdreq),
        .step    (RD_STEP),
        .limit   (bank_words[rbank]),
        .passes  (reuse_eff),
        .offset  (rd_off),
        .last    (rd_last)
    );

    a_wr_needs_ready: assert property (@(posedge clk) disable iff (reset)
        mem_wrreq |-> mem_ready);
    a_bank_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(mem_wrreq && mem_rdreq && (wbank == rbank)));
    a_tile_multiple: assert property (@(posedge clk) disable iff (reset)
        (ld_st == LD_LOAD) |-> ((bank_words[wbank] % RD_STEP) == '0));
endmodule
